// File: rtl/crc_frame_check_if.sv
// crc_frame_check_if
//   Byte-stream and verdict signals of the receive-side CRC-8 frame checker.
//   master : byte source / verdict consumer (drives rx_en, rx_data)
//   slave  : crc_frame_check itself (drives everything else)
//   Signals:
//     rx_en, rx_data          one-cycle strobe + received byte
//     busy                    CRC engine shifting a byte
//     frame_done, resp_en     one-cycle pulse at frame end
//     frame_ok, status        verdict (status held until next frame_done)
//     crc_calc, resp_data     computed payload CRC, verdict byte
//     frame_cnt, err_cnt      saturating frame / error counters
interface crc_frame_check_if #(
  parameter int CNT_W = 16
);
  logic             rx_en;
  logic [7:0]       rx_data;
  logic             busy;
  logic             frame_done;
  logic             frame_ok;
  logic [1:0]       status;
  logic [7:0]       crc_calc;
  logic [7:0]       resp_data;
  logic             resp_en;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output rx_en, rx_data,
    input  busy, frame_done, frame_ok, status, crc_calc,
           resp_data, resp_en, frame_cnt, err_cnt
  );

  modport slave (
    input  rx_en, rx_data,
    output busy, frame_done, frame_ok, status, crc_calc,
           resp_data, resp_en, frame_cnt, err_cnt
  );
endinterface

// File: rtl/crc_frame_check.sv
// crc_frame_check
//   Receive-side CRC-8 verifier for UART byte frames [LEN][payload x LEN][CRC].
//   CRC-8 poly 0x07, init 0x00, MSB-first, no reflection, no final xor,
//   computed bit-serially over the payload only and compared with the
//   trailing CRC byte. One verdict pulse per frame, one cycle after the
//   byte that ends it (CRC byte or bad LEN byte), plus a verdict byte
//   (0xA5 ok / 0x5A error) strobed for a UART transmitter.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    crc_frame_check_if.slave (byte input, verdict outputs, counters)
//   Status codes: 00 ok, 01 crc mismatch, 10 bad length, 11 timeout/overrun.
module crc_frame_check #(
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT_CYC = 500000,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  crc_frame_check_if.slave    bus
);

  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [7:0] RESP_OK  = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'h5A;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_CRC_ERR = 2'b01;
  localparam logic [1:0] ST_BAD_LEN = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_SHIFT,
    S_CRCB,
    S_REPORT
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       crc, crc_nx;
  logic [7:0]       sh, sh_nx;
  logic [7:0]       rem, rem_nx;
  logic [2:0]       bit_cnt, bit_cnt_nx;
  logic [TW-1:0]    tmo, tmo_nx;

  logic             fb;
  logic [7:0]       crc_step;
  logic             tmo_active;
  logic             tmo_hit;

  logic             rep_go;
  logic [1:0]       rep_status;
  logic [7:0]       rep_crc;

  logic             frame_ok_q;
  logic [1:0]       status_q;
  logic [7:0]       crc_calc_q;
  logic [7:0]       resp_data_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  // One serial CRC step, MSB of the data byte first.
  always_comb begin
    fb       = crc[7] ^ sh[7];
    crc_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  end

  // Inter-byte timeout only runs while a frame is open; any strobe restarts it.
  // tmo_hit fires on the cycle that would make the idle count reach TIMEOUT_CYC.
  always_comb begin
    tmo_active = (state == S_DATA) || (state == S_SHIFT) || (state == S_CRCB);
    tmo_hit    = tmo_active && !bus.rx_en && (tmo == TW'(TIMEOUT_CYC - 1));
    if (!tmo_active || bus.rx_en) begin
      tmo_nx = '0;
    end else begin
      tmo_nx = tmo + 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    crc_nx     = crc;
    sh_nx      = sh;
    rem_nx     = rem;
    bit_cnt_nx = bit_cnt;
    rep_go     = 1'b0;
    rep_status = ST_OK;
    rep_crc    = crc;

    case (state)
      S_IDLE: begin
        if (bus.rx_en) begin
          if ((bus.rx_data == 8'h00) || (bus.rx_data > MAX_LEN8)) begin
            rep_go     = 1'b1;
            rep_status = ST_BAD_LEN;
            rep_crc    = 8'h00;
          end else begin
            crc_nx   = 8'h00;
            rem_nx   = bus.rx_data;
            state_nx = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (bus.rx_en) begin
          sh_nx      = bus.rx_data;
          bit_cnt_nx = 3'd0;
          state_nx   = S_SHIFT;
        end else if (tmo_hit) begin
          rep_go     = 1'b1;
          rep_status = ST_ABORT;
        end
      end

      S_SHIFT: begin
        // A new byte while still shifting means the source outran the engine;
        // the frame is abandoned with whatever CRC has accumulated so far.
        if (bus.rx_en || tmo_hit) begin
          rep_go     = 1'b1;
          rep_status = ST_ABORT;
        end else begin
          crc_nx     = crc_step;
          sh_nx      = {sh[6:0], 1'b0};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rem_nx   = rem - 8'd1;
            state_nx = (rem == 8'd1) ? S_CRCB : S_DATA;
          end
        end
      end

      S_CRCB: begin
        if (bus.rx_en) begin
          rep_go     = 1'b1;
          rep_status = (bus.rx_data == crc) ? ST_OK : ST_CRC_ERR;
        end else if (tmo_hit) begin
          rep_go     = 1'b1;
          rep_status = ST_ABORT;
        end
      end

      S_REPORT: begin
        // Any strobe here is dropped; the line is idle again next cycle.
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (rep_go) begin
      state_nx = S_REPORT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      crc     <= '0;
      sh      <= '0;
      rem     <= '0;
      bit_cnt <= '0;
      tmo     <= '0;
    end else begin
      state   <= state_nx;
      crc     <= crc_nx;
      sh      <= sh_nx;
      rem     <= rem_nx;
      bit_cnt <= bit_cnt_nx;
      tmo     <= tmo_nx;
    end
  end

  // Verdict registers load on the edge entering REPORT, so they are already
  // valid during the frame_done cycle and then hold until the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok_q  <= 1'b0;
      status_q    <= '0;
      crc_calc_q  <= '0;
      resp_data_q <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (rep_go) begin
      frame_ok_q  <= (rep_status == ST_OK);
      status_q    <= rep_status;
      crc_calc_q  <= rep_crc;
      resp_data_q <= (rep_status == ST_OK) ? RESP_OK : RESP_ERR;
      if (frame_cnt_q != '1) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if ((rep_status != ST_OK) && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy       = (state == S_SHIFT);
    bus.frame_done = (state == S_REPORT);
    bus.resp_en    = (state == S_REPORT);
    bus.frame_ok   = frame_ok_q;
    bus.status     = status_q;
    bus.crc_calc   = crc_calc_q;
    bus.resp_data  = resp_data_q;
    bus.frame_cnt  = frame_cnt_q;
    bus.err_cnt    = err_cnt_q;
  end

endmodule
